msfsm_mealy_param: RTL and testbench

MSFSM_MEALY_PARAM -- requirements
Module: msfsm_mealy_param

---
 rtl/msfsm_mealy_param.sv | 93 +++++++++
 tb/tb_msfsm_mealy_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/msfsm_mealy_param.sv
// Parameterised one-hot place/transition FSM: barrier-gated Mealy fire strobe,
// lowest-index priority, sticky illegal-state recovery and a saturating fire counter.
module msfsm_mealy_param #(
  parameter int unsigned N_PLACES   = 4,
  parameter int unsigned N_TRANS    = 5,
  parameter int unsigned MAX_TB     = 2,
  parameter int unsigned PW         = 5,
  parameter logic [N_TRANS*PW-1:0] SRC_PLACE = {5'd3, 5'd1, 5'd0, 5'd2, 5'd2},
  parameter logic [N_TRANS*PW-1:0] DST_PLACE = {5'd2, 5'd3, 5'd3, 5'd1, 5'd0},
  parameter logic [N_TRANS*MAX_TB-1:0] TB_MASK = '1,
  parameter int unsigned INIT_PLACE = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [N_TRANS-1:0]        trig,
  input  logic [N_TRANS*MAX_TB-1:0] tb,
  output logic [N_PLACES-1:0]       place,
  output logic [N_TRANS-1:0]        fire,
  output logic [N_TRANS-1:0]        fired_q,
  output logic [15:0]               fire_cnt,
  output logic                      err
);

  localparam int unsigned CNT_W = 16;
  localparam logic [N_PLACES-1:0] INIT_ONEHOT = N_PLACES'(1) << INIT_PLACE;
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

  logic [N_PLACES-1:0] state;
  logic [N_PLACES-1:0] state_next;
  logic                err_next;
  logic [N_TRANS-1:0]  sync;
  logic                legal;
  logic                found;
  logic [N_PLACES-1:0] src_mask;
  logic [N_PLACES-1:0] dst_mask;

  assign legal = (state != '0) && ((state & (state - N_PLACES'(1))) == '0);
  assign place = legal ? state : '0;

  // Masked-off barrier inputs read as 1, so only used barriers can block a trigger.
  always_comb begin
    sync = '0;
    for (int unsigned k = 0; k < N_TRANS; k++) begin
      sync[k] = trig[k] & (&(tb[k*MAX_TB +: MAX_TB] | ~TB_MASK[k*MAX_TB +: MAX_TB]));
    end
  end

  // Next-state logic: priority fire selection, illegal-state recovery, hold freeze.
  always_comb begin
    fire       = '0;
    found      = 1'b0;
    src_mask   = '0;
    dst_mask   = '0;
    state_next = state;
    err_next   = err | ~legal;
    if (!reset && !hold && legal) begin
      for (int unsigned k = 0; k < N_TRANS; k++) begin
        if (!found && sync[k] &&
            ((state & (N_PLACES'(1) << SRC_PLACE[k*PW +: PW])) != '0)) begin
          fire[k]  = 1'b1;
          found    = 1'b1;
          src_mask = N_PLACES'(1) << SRC_PLACE[k*PW +: PW];
          dst_mask = N_PLACES'(1) << DST_PLACE[k*PW +: PW];
        end
      end
    end
    if (!hold) begin
      if (!legal) begin
        state_next = INIT_ONEHOT;
      end else if (found) begin
        state_next = (state & ~src_mask) | dst_mask;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT_ONEHOT;
      fired_q  <= '0;
      fire_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state   <= state_next;
      fired_q <= fire;
      err     <= err_next;
      if ((fire != '0) && (fire_cnt != CNT_MAX)) begin
        fire_cnt <= fire_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_msfsm_mealy_param.sv
// Directed bench for msfsm_mealy_param with default parameters
// (t0:2->0, t1:2->1, t2:0->3, t3:1->3, t4:3->2, reset place 2).
module tb_msfsm_mealy_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [4:0]  trig;
  logic [9:0]  tb;
  logic [3:0]  place;
  logic [4:0]  fire;
  logic [4:0]  fired_q;
  logic [15:0] fire_cnt;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  msfsm_mealy_param dut (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .trig     (trig),
    .tb       (tb),
    .place    (place),
    .fire     (fire),
    .fired_q  (fired_q),
    .fire_cnt (fire_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    trig  = '0;
    hold  = 1'b0;
    tb    = '1;
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    trig  = '0;
    tb    = '1;
    #1;
    check("rst_place",   32'(place),    32'h4);
    check("rst_fire",    32'(fire),     32'h0);
    check("rst_fired_q", 32'(fired_q),  32'h0);
    check("rst_cnt",     32'(fire_cnt), 32'h0);
    check("rst_err",     32'(err),      32'h0);
    trig = 5'b00001;
    #1;
    check("rst_gates_fire", 32'(fire), 32'h0);

    // Lowest enabled transition wins
    do_reset();
    trig = 5'b00011;
    #1;
    check("prio_fire", 32'(fire), 32'h01);
    tick();
    check("prio_place",   32'(place),    32'h1);
    check("prio_fired_q", 32'(fired_q),  32'h01);
    check("prio_cnt",     32'(fire_cnt), 32'h1);

    // Barrier of t0 low hands the fire to t1
    do_reset();
    tb   = 10'b11_1111_1101;
    trig = 5'b00011;
    #1;
    check("barrier_fire", 32'(fire), 32'h02);
    tick();
    check("barrier_place", 32'(place),    32'h2);
    check("barrier_cnt",   32'(fire_cnt), 32'h1);
    tb   = '1;
    trig = 5'b00001;
    #1;
    check("noen_fire", 32'(fire), 32'h0);
    tick();
    check("noen_place",   32'(place),    32'h2);
    check("noen_cnt",     32'(fire_cnt), 32'h1);
    check("noen_fired_q", 32'(fired_q),  32'h0);

    // t0, t2, t4 round trip with a 3-clock hold in the middle
    do_reset();
    trig = 5'b00001;
    tick();
    check("cyc_p0", 32'(place), 32'h1);
    trig = 5'b00100;
    #1;
    check("cyc_t2_fire", 32'(fire), 32'h04);
    hold = 1'b1;
    #1;
    check("hold_fire", 32'(fire), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_place", 32'(place),    32'h1);
      check("hold_cnt",   32'(fire_cnt), 32'h1);
      check("hold_fire2", 32'(fire),     32'h0);
    end
    check("hold_fired_q", 32'(fired_q), 32'h0);
    hold = 1'b0;
    tick();
    check("cyc_p3", 32'(place), 32'h8);
    trig = 5'b10000;
    tick();
    check("cyc_p2",  32'(place),    32'h4);
    check("cyc_cnt", 32'(fire_cnt), 32'h3);

    // Illegal state: held under hold, recovered to place 2 without hold
    do_reset();
    trig = 5'b00001;
    hold = 1'b1;
    force dut.state = 4'b0110;
    #1;
    check("ill_place", 32'(place), 32'h0);
    check("ill_fire",  32'(fire),  32'h0);
    tick();
    check("ill_hold_err", 32'(err), 32'h1);
    hold = 1'b0;
    #1;
    check("ill_nohold_fire", 32'(fire), 32'h0);
    tick();
    check("ill_err",      32'(err),      32'h1);
    check("ill_cnt",      32'(fire_cnt), 32'h0);
    check("ill_fired_q",  32'(fired_q),  32'h0);
    trig = '0;
    release dut.state;
    tick();
    check("ill_recover", 32'(place), 32'h4);
    trig = 5'b00001;
    tick();
    check("ill_post_place", 32'(place), 32'h1);
    check("ill_post_err",   32'(err),   32'h1);
    do_reset();
    check("ill_err_clr", 32'(err), 32'h0);

    // Continuous firing to saturation, then an asynchronous reset pulse
    trig = '1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", 32'(fire_cnt), 32'hFFFE);
    tick();
    check("sat_ffff", 32'(fire_cnt), 32'hFFFF);
    check("sat_fire", 32'(fire != '0), 32'h1);
    tick();
    check("sat_hold", 32'(fire_cnt), 32'hFFFF);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_place",   32'(place),    32'h4);
    check("async_cnt",     32'(fire_cnt), 32'h0);
    check("async_fired_q", 32'(fired_q),  32'h0);
    check("async_err",     32'(err),      32'h0);
    check("async_fire",    32'(fire),     32'h0);
    reset = 1'b0;
    #1;
    check("rel_fire", 32'(fire), 32'h01);
    tick();
    check("rel_place", 32'(place),    32'h1);
    check("rel_cnt",   32'(fire_cnt), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
